// File: rtl/seq_sub64_if.sv
// Operand/result handshake bundle for seq_sub64.
// SEQ_SUB64_OVF_EN adds the signed-overflow result flag.
interface seq_sub64_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
`ifdef SEQ_SUB64_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
`ifdef SEQ_SUB64_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
`ifdef SEQ_SUB64_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/seq_sub64.sv
// Slice-serial subtractor: diff = a - b - bin, one SLICE-bit chunk per clock, LSB first.
// Define SEQ_SUB64_OVF_EN to add the signed-overflow output ovf.
module seq_sub64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_sub64_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("seq_sub64: WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             zero_q;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE:0]   sum;
    logic             last;
    int unsigned      off;
`ifdef SEQ_SUB64_OVF_EN
    logic             ovf_q;
`endif

    // State and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags are decoded from the next state so they change on the same edge as the state
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            IDLE:    in_ready_d  = 1'b1;
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Borrow-chain step for the current slice: a + ~b + ~borrow, carry-out is the inverted borrow
    always_comb begin
        off    = 32'(cnt_q) * SLICE;
        a_s    = a_q[off +: SLICE];
        b_s    = b_q[off +: SLICE];
        sum    = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, ~borrow_q};
        last   = (cnt_q == LAST);
        diff_d = diff_q;
        diff_d[off +: SLICE] = sum[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SEQ_SUB64_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    diff_q   <= diff_d;
                    borrow_q <= ~sum[SLICE];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last) begin
                        bout_q <= ~sum[SLICE];
                        zero_q <= (diff_d == '0);
`ifdef SEQ_SUB64_OVF_EN
                        ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
`ifdef SEQ_SUB64_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub64.sv
// Directed plus randomized checks of seq_sub64 against a plain-arithmetic subtraction model.
module tb_seq_sub64;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    seq_sub64_if #(.WIDTH(64)) bus ();

    seq_sub64 #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 65-bit result: low 64 bits are the difference, top bit set iff a < b + bin
    function automatic logic [64:0] model_sub(input logic [63:0] ma, input logic [63:0] mb,
                                              input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - 65'(mbin);
    endfunction

    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tbin,
                         input int hold, input bit pulse);
        logic [64:0] r;
        logic        exp_zero;
        logic        exp_ovf;
        int          edges;
        r        = model_sub(ta, tb_, tbin);
        exp_zero = (r[63:0] == 64'd0);
        exp_ovf  = (ta[63] != tb_[63]) && (r[63] != ta[63]);
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.a = ta; bus.b = tb_; bus.bin = tbin; bus.in_valid = 1'b1;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.bin = 1'($urandom);
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("latency", 64'(edges), 64'd5);
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("in_ready_done", 64'(bus.in_ready), 64'd0);
        check("diff", bus.diff, r[63:0]);
        check("bout", 64'(bus.bout), 64'(r[64]));
        check("zero", 64'(bus.zero), 64'(exp_zero));
`ifdef SEQ_SUB64_OVF_EN
        check("ovf", 64'(bus.ovf), 64'(exp_ovf));
`else
        if (exp_ovf) edges = edges + 0;
`endif
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = pulse && (i == 3);
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_ready", 64'(bus.in_ready), 64'd0);
            check("hold_diff", bus.diff, r[63:0]);
            check("hold_bout", 64'(bus.bout), 64'(r[64]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("exit_valid", 64'(bus.out_valid), 64'd0);
        check("exit_ready", 64'(bus.in_ready), 64'd1);
        check("exit_diff", bus.diff, r[63:0]);
        check("exit_zero", 64'(bus.zero), 64'(exp_zero));
        if (pulse) begin
            @(negedge clk);
            check("pulse_not_taken", 64'(bus.out_valid), 64'd0);
            check("pulse_ready", 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_diff", bus.diff, 64'd0);
        check("rst_bout", 64'(bus.bout), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(64'h0000_0000_0001_0000, 64'd1, 1'b0, 0, 1'b0);
        do_op(64'd0, 64'd0, 1'b1, 0, 1'b0);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0, 1'b0);
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0);
        do_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 10, 1'b1);

        // Abort mid-RUN: outputs must drop to reset values without waiting for a clock edge
        @(negedge clk);
        bus.a = 64'hFFFF_0000_FFFF_0000; bus.b = 64'h0000_1111_0000_2222;
        bus.bin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_diff", bus.diff, 64'd0);
        check("abort_bout", 64'(bus.bout), 64'd0);
        check("abort_zero", 64'(bus.zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(64'd5, 64'd3, 1'b0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) rb[63] = ~ra[63];
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
